// File: rtl/binary_arith_pkg.sv
// binary_arith_pkg: shared scheduler state type and width helper
package binary_arith_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MAX counter, advances on en, wrap flags the terminal count
module wrap_counter
  import binary_arith_pkg::*;
#(
  parameter int MAX = 2,
  localparam int W = clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = cnt == W'(MAX - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/binary_matmul_tile_scheduler.sv
// binary_matmul_tile_scheduler: walks activation/weight tiles into the core with
// credit-limited issue and tracks drained output tiles.
module binary_matmul_tile_scheduler
  import binary_arith_pkg::*;
#(
  parameter int ROW_TILES       = 2,
  parameter int COL_TILES       = 3,
  parameter int IN_DEPTH        = 3,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               in1_addr,
  output logic [ADDR_WIDTH-1:0]               in2_addr,
  output logic                                core_in_valid,
  input  logic                                core_in_ready,
  input  logic                                core_out_fire,
  output logic [clog2_min1(ROW_TILES)-1:0]    out_row,
  output logic [clog2_min1(COL_TILES)-1:0]    out_col,
  output logic                                err
);
  localparam int KW = clog2_min1(IN_DEPTH);
  localparam int CW = clog2_min1(COL_TILES);
  localparam int RW = clog2_min1(ROW_TILES);
  localparam int OW = clog2_min1(MAX_OUTSTANDING + 1);
  if (64'(ROW_TILES * COL_TILES * IN_DEPTH - 1) >= (64'(1) << ADDR_WIDTH)) begin : g_addr_overflow
    $error("buffer addresses do not fit in ADDR_WIDTH");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_credit_range
    $error("MAX_OUTSTANDING must be 1..8");
  end
  sched_state_t state, state_nx;
  logic [OW-1:0] outstanding;
  logic [KW-1:0] k;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic k_wrap, c_wrap, r_wrap, row_wrap, col_wrap;
  logic issue_fire, beat_last, run_last, drain_ok, drain_last;
  assign issue_fire = core_in_valid & core_in_ready;
  assign beat_last  = issue_fire & k_wrap;
  assign run_last   = beat_last & c_wrap & r_wrap;
  // fires with nothing outstanding are protocol errors and must not move any count
  assign drain_ok   = core_out_fire & (state != IDLE) & (outstanding != '0);
  assign drain_last = drain_ok & col_wrap & row_wrap;
  // credit is only consulted at a tile's first beat
  assign core_in_valid = (state == ISSUE) && (outstanding < OW'(MAX_OUTSTANDING) || k != '0);
  assign in1_addr = ADDR_WIDTH'(r) * ADDR_WIDTH'(IN_DEPTH) + ADDR_WIDTH'(k);
  assign in2_addr = ADDR_WIDTH'(c) * ADDR_WIDTH'(IN_DEPTH) + ADDR_WIDTH'(k);
  assign busy = state != IDLE;
  assign done = state == DONE;
  wrap_counter #(.MAX(IN_DEPTH))  u_k   (.clk, .rst, .en(issue_fire),                 .cnt(k),       .wrap(k_wrap));
  wrap_counter #(.MAX(COL_TILES)) u_c   (.clk, .rst, .en(beat_last),                  .cnt(c),       .wrap(c_wrap));
  wrap_counter #(.MAX(ROW_TILES)) u_r   (.clk, .rst, .en(beat_last & c_wrap),         .cnt(r),       .wrap(r_wrap));
  wrap_counter #(.MAX(COL_TILES)) u_col (.clk, .rst, .en(drain_ok),                   .cnt(out_col), .wrap(col_wrap));
  wrap_counter #(.MAX(ROW_TILES)) u_row (.clk, .rst, .en(drain_ok & col_wrap),        .cnt(out_row), .wrap(row_wrap));
  // every issued tile drains exactly once, so the final drain wrap means outstanding hits 0
  always_comb
    state_nx = (state == IDLE)  ? (start ? ISSUE : IDLE) :
               (state == ISSUE) ? (run_last ? DRAIN : ISSUE) :
               (state == DRAIN) ? (drain_last ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) outstanding <= '0;
    else if (beat_last != drain_ok) outstanding <= beat_last ? outstanding + OW'(1) : outstanding - OW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (core_out_fire && (state == IDLE || outstanding == '0)) err <= 1'b1;
endmodule
